// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (in: clk, rst, sample_tick, rx_enable, parity_enable, rx_in; out: rx_data_out, rx_valid, parity_error, framing_error, busy)
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  rx_enable,
  input  logic                  parity_enable,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0] state;
  logic [1:0] sync;
  logic rx_s, armed, par_en, par_err, mid, last;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  assign rx_s = sync[1];
  assign mid  = sample_tick && tick_cnt == TW'(OVERSAMPLE / 2 - 1);
  assign last = sample_tick && tick_cnt == TW'(OVERSAMPLE - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync          <= 2'b11;
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      rx_data_out   <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      armed         <= 1'b1;
      par_en        <= 1'b0;
      par_err       <= 1'b0;
    end else begin
      sync     <= {sync[0], rx_in};
      rx_valid <= 1'b0;
      if (state != IDLE && sample_tick) tick_cnt <= last ? '0 : tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          armed <= rx_s | (armed & rx_enable);
          if (rx_enable && !rx_s && armed) begin
            state    <= START;
            tick_cnt <= '0;
            par_en   <= parity_enable;
          end
        end
        START: if (mid) begin
          state    <= rx_s ? IDLE : DATA;
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
        DATA: if (last) begin
          shift   <= {rx_s, shift[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(DATA_WIDTH - 1)) state <= par_en ? PARITY : STOP;
        end
        PARITY: if (last) begin
          par_err <= rx_s ^ (^shift);
          state   <= STOP;
        end
        STOP: if (last) begin
          state         <= IDLE;
          rx_data_out   <= shift;
          rx_valid      <= 1'b1;
          framing_error <= !rx_s;
          parity_error  <= par_en & par_err;
          armed         <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
